// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Brief    : Shared state encoding and digit constants for bcd_encoder_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam logic [3:0] BCD_ADJ_TH = 4'd4;

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
// Module   : bcd_digit_adj
// Brief    : Combinational add-3-if-greater-than-4 correction for one digit.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit > BCD_ADJ_TH) ? (i_digit + 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bcd_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bcd_encoder_pipe
// Brief    : Sequential shift-and-add-3 binary-to-BCD converter with
//            valid/ready handshakes; optional leading-zero blanking via
//            the BCD_ENC_BLANK_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_encoder_pipe
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [BIN_W-1:0]      i_binary,
    input  logic                  i_signed,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [4*DIGITS-1:0]   o_bcd,
    output logic                  o_neg,
    output logic                  o_ovf
);

    localparam int               c_CNT_W = $clog2(BIN_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(BIN_W - 1);

    bcd_state_t            r_state;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [BIN_W-1:0]      r_mag;
    logic [4*DIGITS-1:0]   r_bcd;
    logic                  r_ovf;

    logic [BIN_W-1:0]      w_in_mag;
    logic [4*DIGITS-1:0]   w_adj;
    logic [4*DIGITS-1:0]   w_bcd_sh;
    logic                  w_carry;
    logic [BIN_W-1:0]      w_mag_sh;
    logic                  w_ovf_next;
    logic [4*DIGITS-1:0]   w_final;

    // Two's-complement negate stays in BIN_W bits so the signed minimum maps to 2**(BIN_W-1).
    assign w_in_mag = (i_signed && i_binary[BIN_W-1]) ? (~i_binary + 1'b1) : i_binary;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            bcd_digit_adj u_adj (
                .i_digit (r_bcd[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    assign {w_carry, w_bcd_sh} = {w_adj, r_mag[BIN_W-1]};
    assign w_mag_sh            = {r_mag[BIN_W-2:0], 1'b0};
    assign w_ovf_next          = r_ovf | w_carry;

`ifdef BCD_ENC_BLANK_EN
    logic w_seen_nz;

    always_comb begin
        w_final   = w_bcd_sh;
        w_seen_nz = 1'b0;
        if (!w_ovf_next) begin
            for (int k = DIGITS - 1; k >= 1; k--) begin
                if (w_bcd_sh[4*k +: 4] != 4'd0) begin
                    w_seen_nz = 1'b1;
                end
                if (!w_seen_nz) begin
                    w_final[4*k +: 4] = BCD_BLANK;
                end
            end
        end
    end
`else
    assign w_final = w_bcd_sh;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_mag   <= '0;
            r_bcd   <= '0;
            r_ovf   <= 1'b0;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_bcd   <= '0;
            o_neg   <= 1'b0;
            o_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_mag   <= w_in_mag;
                        o_neg   <= i_signed & i_binary[BIN_W-1];
                        r_bcd   <= '0;
                        r_ovf   <= 1'b0;
                        r_cnt   <= '0;
                        o_ready <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_mag <= w_mag_sh;
                    r_bcd <= w_bcd_sh;
                    r_ovf <= w_ovf_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        o_bcd   <= w_final;
                        o_ovf   <= w_ovf_next;
                        o_valid <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd_encoder_pipe
// Brief    : Scoreboard bench for bcd_encoder_pipe (5-digit and 4-digit builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd_encoder_pipe;

    localparam int BIN_W = 16;

    typedef struct packed {
        logic [19:0] bcd;
        logic        neg;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic        i_signed;
    logic        i_ready;
    logic [15:0] i_binary;

    logic        rdy5, vld5, neg5, ovf5;
    logic [19:0] bcd5;
    logic        rdy4, vld4, neg4, ovf4;
    logic [15:0] bcd4;

    exp_t q5[$];
    exp_t q4[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    bcd_encoder_pipe #(.BIN_W(16), .DIGITS(5)) dut5 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy5),
        .i_binary(i_binary), .i_signed(i_signed), .o_valid(vld5),
        .i_ready(i_ready), .o_bcd(bcd5), .o_neg(neg5), .o_ovf(ovf5)
    );

    bcd_encoder_pipe #(.BIN_W(16), .DIGITS(4)) dut4 (
        .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(rdy4),
        .i_binary(i_binary), .i_signed(i_signed), .o_valid(vld4),
        .i_ready(i_ready), .o_bcd(bcd4), .o_neg(neg4), .o_ovf(ovf4)
    );

    // Decimal reference: plain integer arithmetic on the magnitude.
    function automatic exp_t model(input logic [15:0] bin, input logic sgn, input int d);
        exp_t e;
        int   mag, v, top, p, dig;
        e.neg = sgn & bin[15];
        mag   = e.neg ? (65536 - int'({16'd0, bin})) : int'({16'd0, bin});
        p = 1;
        for (int k = 0; k < d; k++) p = p * 10;
        e.ovf = (mag >= p);
        e.bcd = '0;
        v     = mag;
        top   = 0;
        for (int k = 0; k < d; k++) begin
            dig = v % 10;
            v   = v / 10;
            if (dig != 0) top = k;
            e.bcd[4*k +: 4] = 4'(dig);
        end
`ifdef BCD_ENC_BLANK_EN
        if (!e.ovf)
            for (int k = top + 1; k < d; k++) e.bcd[4*k +: 4] = 4'hF;
`endif
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin : mon5
        exp_t e;
        if (!rst && vld5 && i_ready) begin
            if (q5.size() == 0) begin
                chk("unexpected_out5", 32'(bcd5), 32'hFFFF_FFFF);
            end else begin
                e = q5.pop_front();
                chk("bcd5", 32'(bcd5), 32'(e.bcd));
                chk("neg5", 32'(neg5), 32'(e.neg));
                chk("ovf5", 32'(ovf5), 32'(e.ovf));
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp_t e;
        if (!rst && vld4 && i_ready) begin
            if (q4.size() == 0) begin
                chk("unexpected_out4", 32'(bcd4), 32'hFFFF_FFFF);
            end else begin
                e = q4.pop_front();
                chk("bcd4", 32'(bcd4), 32'(e.bcd[15:0]));
                chk("neg4", 32'(neg4), 32'(e.neg));
                chk("ovf4", 32'(ovf4), 32'(e.ovf));
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!rdy5 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!rdy5) chk("ready_timeout", 32'(rdy5), 32'd1);
    endtask

    task automatic issue(input logic [15:0] bin, input logic sgn);
        i_binary = bin;
        i_signed = sgn;
        i_valid  = 1'b1;
        q5.push_back(model(bin, sgn, 5));
        q4.push_back(model(bin, sgn, 4));
        @(posedge clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q5.size() + q4.size()) != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 32'(q5.size() + q4.size()), 32'd0);
    endtask

    // Latency counted in edges with the accept edge as the first.
    task automatic convert(input logic [15:0] bin, input logic sgn);
        int n;
        wait_ready();
        issue(bin, sgn);
        n = 1;
        while (!vld5 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", 32'(n), 32'(BIN_W + 1));
        drain();
    endtask

    logic [15:0] dir_bin [8] = '{16'hFFFF, 16'h8000, 16'hFFFF, 16'h8000,
                                 16'd12345, 16'd9999, 16'd0, 16'd407};
    logic        dir_sgn [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin : main
        exp_t e;
        int   n;
        rst      = 1'b1;
        i_valid  = 1'b0;
        i_signed = 1'b0;
        i_binary = '0;
        i_ready  = 1'b1;
        #12;
        chk("rst_ready", 32'(rdy5), 32'd1);
        chk("rst_valid", 32'(vld5), 32'd0);
        chk("rst_bcd",   32'(bcd5), 32'd0);
        chk("rst_neg",   32'(neg5), 32'd0);
        chk("rst_ovf",   32'(ovf5), 32'd0);
        chk("rst_ready4", 32'(rdy4), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) convert(dir_bin[i], dir_sgn[i]);
        for (int i = 0; i < 30; i++) convert(16'($urandom), 1'($urandom));

        // Consumer stall: result must hold while new requests are ignored.
        i_ready = 1'b0;
        wait_ready();
        issue(16'd50321, 1'b0);
        e = model(16'd50321, 1'b0, 5);
        n = 0;
        while (!vld5 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 i_valid = 1'b1;
            i_binary = 16'd7;
            @(negedge clk);
            chk("hold_valid", 32'(vld5), 32'd1);
            chk("hold_bcd",   32'(bcd5), 32'(e.bcd));
            chk("hold_ready", 32'(rdy5), 32'd0);
        end
        @(posedge clk);
        #1 i_valid = 1'b0;
        i_ready = 1'b1;
        drain();
        repeat (25) @(negedge clk);
        chk("no_extra_valid", 32'(vld5), 32'd0);

        // Reset mid-conversion aborts with no result.
        wait_ready();
        issue(16'd1234, 1'b1);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_ready", 32'(rdy5), 32'd1);
        chk("abort_valid", 32'(vld5), 32'd0);
        chk("abort_bcd",   32'(bcd5), 32'd0);
        chk("abort_neg",   32'(neg5), 32'd0);
        chk("abort_ovf",   32'(ovf5), 32'd0);
        q5.delete();
        q4.delete();
        @(negedge clk);
        rst = 1'b0;
        convert(16'd42, 1'b0);

        repeat (5) @(negedge clk);
        chk("final_queue", 32'(q5.size() + q4.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
